// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-unit results, with busy scoreboard.
// Optional macro REGWB_STARVE_GUARD_EN forces a FIFO pop after repeated pipeline blocking.
package rysyPkg;
  localparam int REG_LEN = 32;
  localparam int REG_NUM = 32;
endpackage

module regwb_arbiter
  import rysyPkg::*;
#(
  parameter int ADDR_LEN   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pipe_wr,
  input  logic [ADDR_LEN-1:0] pipe_rd,
  input  logic [REG_LEN-1:0]  pipe_d,
  input  logic                issue_valid,
  input  logic [ADDR_LEN-1:0] issue_rd,
  input  logic                lu_valid,
  input  logic [ADDR_LEN-1:0] lu_rd,
  input  logic [REG_LEN-1:0]  lu_d,
  output logic                lu_ready,
  input  logic [ADDR_LEN-1:0] rs1,
  input  logic [ADDR_LEN-1:0] rs2,
  output logic                hazard,
  output logic                pipe_hold,
  output logic [ADDR_LEN-1:0] rd,
  output logic [REG_LEN-1:0]  rd_d,
  output logic                reg_wr
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SEL_PIPE, SEL_FIFO, FORCE} sel_e;

  sel_e                state_q, state_d;
  logic [ADDR_LEN-1:0] fifo_rd_q [FIFO_DEPTH];
  logic [REG_LEN-1:0]  fifo_dat_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                full, empty, push, pop, take_pipe, force_pop;
  logic [ADDR_LEN-1:0] rd_q;
  logic [REG_LEN-1:0]  rd_d_q;
  logic                reg_wr_q, from_fifo_q;
  logic [REG_NUM-1:0]  busy_q, busy_d;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign lu_ready = !full;
  assign push     = lu_valid && !full;

`ifdef REGWB_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;
  logic       hold_q;
  assign force_pop = (state_q == FORCE);
  assign pipe_hold = hold_q;
`else
  assign force_pop = 1'b0;
  assign pipe_hold = 1'b0;
`endif

  always_comb begin
    take_pipe = 1'b0;
    pop       = 1'b0;
    if (force_pop)   pop = !empty;
    else if (pipe_wr) take_pipe = 1'b1;
    else if (!empty)  pop = 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEL_PIPE: if (!pipe_wr && !empty) state_d = SEL_FIFO;
      SEL_FIFO: if (pipe_wr || count_d == '0) state_d = SEL_PIPE;
      FORCE:    state_d = SEL_PIPE;
      default:  state_d = SEL_PIPE;
    endcase
`ifdef REGWB_STARVE_GUARD_EN
    starve_d = starve_q;
    if (pop) starve_d = 2'd0;
    else if (pipe_wr && !empty && starve_q != 2'd3) starve_d = starve_q + 2'd1;
    if (starve_d == 2'd3 && state_q != FORCE) state_d = FORCE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEL_PIPE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

`ifdef REGWB_STARVE_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= (state_d == FORCE);
    end
  end
`endif

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]  <= lu_rd;
      fifo_dat_q[wr_ptr_q] <= lu_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      rd_d_q      <= '0;
      reg_wr_q    <= 1'b0;
      from_fifo_q <= 1'b0;
    end else if (take_pipe) begin
      rd_q        <= pipe_rd;
      rd_d_q      <= pipe_d;
      reg_wr_q    <= (pipe_rd != '0);
      from_fifo_q <= 1'b0;
    end else if (pop) begin
      rd_q        <= fifo_rd_q[rd_ptr_q];
      rd_d_q      <= fifo_dat_q[rd_ptr_q];
      reg_wr_q    <= (fifo_rd_q[rd_ptr_q] != '0);
      from_fifo_q <= 1'b1;
    end else begin
      reg_wr_q    <= 1'b0;
      from_fifo_q <= 1'b0;
    end
  end

  // Clear is applied before set so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_wr_q && from_fifo_q) busy_d[rd_q] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign hazard = busy_q[rs1] | busy_q[rs2];
  assign rd     = rd_q;
  assign rd_d   = rd_d_q;
  assign reg_wr = reg_wr_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter: writeback timing, FIFO ordering, scoreboard hazards, x0 handling, reset.
module tb_regwb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wr;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_d;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_d;
  logic        lu_ready;
  logic [4:0]  rs1, rs2;
  logic        hazard, pipe_hold;
  logic [4:0]  rd;
  logic [31:0] rd_d;
  logic        reg_wr;

  int checks = 0;
  int errors = 0;

  regwb_arbiter #(.ADDR_LEN(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr(pipe_wr), .pipe_rd(pipe_rd), .pipe_d(pipe_d),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_d(lu_d), .lu_ready(lu_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .pipe_hold(pipe_hold),
    .rd(rd), .rd_d(rd_d), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: outputs are stable, inputs may change.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_wr = 0; pipe_rd = 0; pipe_d = 0;
    issue_valid = 0; issue_rd = 0; lu_valid = 0; lu_rd = 0; lu_d = 0;
    rs1 = 0; rs2 = 0;
    #3;
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rd_d", rd_d, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_hazard", hazard, 0);
    chk("rst_pipe_hold", pipe_hold, 0);
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();

    // Pipeline write appears one cycle later, then drops
    pipe_wr = 1; pipe_rd = 5; pipe_d = 32'hA5A5_0001;
    nxt();
    pipe_wr = 0;
    chk("pipe_reg_wr", reg_wr, 1);
    chk("pipe_rd", rd, 5);
    chk("pipe_rd_d", rd_d, 32'hA5A5_0001);
    nxt();
    chk("pipe_drop_reg_wr", reg_wr, 0);
    chk("pipe_hold_rd", rd, 5);
    chk("pipe_hold_rd_d", rd_d, 32'hA5A5_0001);

    // Long-unit result clears its busy bit
    issue_valid = 1; issue_rd = 7;
    nxt();
    issue_valid = 0; rs1 = 7;
    #1 chk("busy7_hazard", hazard, 1);
    lu_valid = 1; lu_rd = 7; lu_d = 32'h1234;
    #1 chk("lu_ready_empty", lu_ready, 1);
    nxt();
    lu_valid = 0;
    chk("lu_no_write_yet", reg_wr, 0);
    nxt();
    chk("lu_reg_wr", reg_wr, 1);
    chk("lu_rd", rd, 7);
    chk("lu_rd_d", rd_d, 32'h1234);
    chk("lu_hazard_during_write", hazard, 1);
    nxt();
    chk("lu_hazard_cleared", hazard, 0);
    chk("lu_write_done", reg_wr, 0);
    rs1 = 0;

`ifndef REGWB_STARVE_GUARD_EN
    // Pipeline blocks the FIFO for 4 cycles; FIFO fills, then drains in order
    pipe_wr = 1; pipe_rd = 1; pipe_d = 32'h0000_0011;
    lu_valid = 1; lu_rd = 10; lu_d = 32'hAAAA_0000;
    nxt();
    pipe_rd = 2; pipe_d = 32'h0000_0022;
    lu_rd = 11; lu_d = 32'hBBBB_0000;
    #1 chk("fill_lu_ready_one", lu_ready, 1);
    chk("blk_rd1", rd, 1);
    nxt();
    lu_valid = 0; pipe_rd = 3; pipe_d = 32'h0000_0033;
    #1 chk("full_lu_ready", lu_ready, 0);
    chk("blk_rd2", rd, 2);
    nxt();
    pipe_rd = 4; pipe_d = 32'h0000_0044;
    chk("blk_rd3", rd, 3);
    chk("still_full", lu_ready, 0);
    nxt();
    pipe_wr = 0;
    chk("blk_rd4", rd, 4);
    chk("blk_wr4", reg_wr, 1);
    chk("full_no_drain", lu_ready, 0);
    nxt();
    chk("drain1_wr", reg_wr, 1);
    chk("drain1_rd", rd, 10);
    chk("drain1_d", rd_d, 32'hAAAA_0000);
    chk("drain1_lu_ready", lu_ready, 1);
    nxt();
    chk("drain2_wr", reg_wr, 1);
    chk("drain2_rd", rd, 11);
    chk("drain2_d", rd_d, 32'hBBBB_0000);
    nxt();
    chk("drain_done", reg_wr, 0);
`endif

    // Reissue of rd=9 in the cycle its FIFO write clears it: stays busy
    issue_valid = 1; issue_rd = 9;
    nxt();
    issue_valid = 0; rs2 = 9;
    lu_valid = 1; lu_rd = 9; lu_d = 32'h9999;
    nxt();
    lu_valid = 0;
    nxt();
    issue_valid = 1; issue_rd = 9;
    chk("reissue_wr", reg_wr, 1);
    chk("reissue_rd", rd, 9);
    nxt();
    issue_valid = 0;
    #1 chk("reissue_hazard", hazard, 1);
    nxt();
    chk("reissue_hazard_held", hazard, 1);
    rs2 = 0;

    // x0 result: popped but never written, never hazards
    lu_valid = 1; lu_rd = 0; lu_d = 32'hFFFF_FFFF;
    #1 chk("x0_hazard_a", hazard, 0);
    nxt();
    lu_valid = 0;
    chk("x0_wr_a", reg_wr, 0);
    nxt();
    chk("x0_wr_b", reg_wr, 0);
    chk("x0_popped", lu_ready, 1);
    chk("x0_hazard_b", hazard, 0);
    nxt();
    chk("x0_wr_c", reg_wr, 0);

    // Asynchronous reset with FIFO full and busy[3] set
    pipe_wr = 1; pipe_rd = 1; pipe_d = 32'h0000_0101;
    issue_valid = 1; issue_rd = 3;
    lu_valid = 1; lu_rd = 3; lu_d = 32'h3333;
    nxt();
    issue_valid = 0; lu_rd = 4; lu_d = 32'h4444;
    nxt();
    lu_valid = 0; rs1 = 3;
    #1 chk("pre_rst_full", lu_ready, 0);
    chk("pre_rst_hazard", hazard, 1);
    chk("pre_rst_wr", reg_wr, 1);
    rst_n = 1'b0; pipe_wr = 0;
    #1 chk("mid_rst_wr", reg_wr, 0);
    chk("mid_rst_lu_ready", lu_ready, 1);
    chk("mid_rst_hazard", hazard, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("post_rst_no_wr", reg_wr, 0);
    end
    chk("post_rst_hazard", hazard, 0);
    chk("post_rst_lu_ready", lu_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
